// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: hazard inputs from ID/EX/MEM and the pipeline control
// outputs of the stall controller, bundled for the core and the controller.
interface hazard_stall_controller_if;
    logic [4:0]  IFID_rs;
    logic [4:0]  IFID_rt;
    logic        ID_usesRt;
    logic [4:0]  IDEX_rt;
    logic        IDEX_MemRead;
    logic        ID_branchTaken;
    logic        EXMEM_memBusy;
    logic        PC_write;
    logic        IFID_write;
    logic        IFID_flush;
    logic        IDEX_bubble;
    logic        pipeFreeze;
    logic [15:0] stallCount;
    logic        memTimeout;

    modport master (
        output IFID_rs, IFID_rt, ID_usesRt, IDEX_rt, IDEX_MemRead, ID_branchTaken, EXMEM_memBusy,
        input  PC_write, IFID_write, IFID_flush, IDEX_bubble, pipeFreeze, stallCount, memTimeout
    );
    modport slave (
        input  IFID_rs, IFID_rt, ID_usesRt, IDEX_rt, IDEX_MemRead, ID_branchTaken, EXMEM_memBusy,
        output PC_write, IFID_write, IFID_flush, IDEX_bubble, pipeFreeze, stallCount, memTimeout
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubbles, taken-branch flush and memory-busy freeze
// for a 5-stage MIPS pipeline, with a stall-cycle counter and sticky memory timeout.
module hazard_stall_controller #(
    parameter int LOAD_STALLS = 1,
    parameter int MAX_WAIT    = 64
) (
    input logic                       Clock,
    input logic                       Reset_n,
    hazard_stall_controller_if.slave  hz
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    state_t      state_q, state_d, eff;
    logic        ret_q, ret_d;
    logic [2:0]  bub_q, bub_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_q, stall_d;
    logic        tmo_q, tmo_d;
    logic        load_use, pc_w, ifid_w, flush, bubble, freeze;

    assign load_use = hz.IDEX_MemRead && hz.IDEX_rt != 5'd0 &&
                      (hz.IDEX_rt == hz.IFID_rs || (hz.ID_usesRt && hz.IDEX_rt == hz.IFID_rt));

    always_comb begin
        // a released MEM_WAIT replays the cycle of the state it interrupted
        eff     = (state_q == MEM_WAIT) ? (ret_q ? LOAD_STALL : RUN) : state_q;
        state_d = state_q;
        ret_d   = ret_q;
        bub_d   = bub_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        freeze  = 1'b0;
        if (hz.EXMEM_memBusy) begin
            freeze  = 1'b1;
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            state_d = MEM_WAIT;
            ret_d   = (state_q == MEM_WAIT) ? ret_q : (state_q == LOAD_STALL);
        end else if (eff == LOAD_STALL) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            bubble  = 1'b1;
            bub_d   = bub_q - 3'd1;
            state_d = (bub_q == 3'd1) ? RUN : LOAD_STALL;
        end else if (load_use) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            bubble  = 1'b1;
            state_d = (LOAD_STALLS == 1) ? RUN : LOAD_STALL;
            bub_d   = (LOAD_STALLS == 1) ? bub_q : 3'(LOAD_STALLS - 1);
        end else begin
            state_d = RUN;
            flush   = hz.ID_branchTaken;
        end
        wait_d  = hz.EXMEM_memBusy ? ((wait_q == 8'hFF) ? wait_q : wait_q + 8'd1) : 8'd0;
        tmo_d   = tmo_q || (hz.EXMEM_memBusy && wait_q == 8'(MAX_WAIT - 1));
        stall_d = (!pc_w && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RUN;
            ret_q   <= 1'b0;
            bub_q   <= 3'd0;
            wait_q  <= 8'd0;
            stall_q <= 16'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bub_q   <= bub_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    assign hz.PC_write    = pc_w;
    assign hz.IFID_write  = ifid_w;
    assign hz.IFID_flush  = flush;
    assign hz.IDEX_bubble = bubble;
    assign hz.pipeFreeze  = freeze;
    assign hz.stallCount  = stall_q;
    assign hz.memTimeout  = tmo_q;
endmodule
